// File: rtl/uart_monitor_pkg.sv
// Shared types and constants for the UART register-bank controller.
package uart_monitor_pkg;

   // Response bytes sent back to the host
   localparam logic [7:0] ACK_BYTE = 8'hA5;
   localparam logic [7:0] NAK_BYTE = 8'h5A;

   // Command FSM states
   typedef enum logic [2:0] {
      IDLE,
      CMD,
      LEN,
      WDATA,
      DRAIN,
      RESP,
      RDATA
   } state_e;

   // Error codes reported on err_code
   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_BAD     = 2'd1,
      ERR_TIMEOUT = 2'd2,
      ERR_RX      = 2'd3
   } err_e;

   // Number of whole bytes needed to carry a register of the given width
   function automatic int reg_bytes(input int bits);
      return (bits + 7) / 8;
   endfunction

endpackage

// File: rtl/uart_reg_bank_ctrl_reg_bank.sv
// Register storage with reset image, read-only bypass to status inputs and
// one-hot write strobes.
module reg_bank #(
   parameter int                           NUM_REGS    = 8,
   parameter int                           REG_BITS    = 32,
   parameter logic [NUM_REGS-1:0]          RO_MASK     = '0,
   parameter logic [NUM_REGS*REG_BITS-1:0] RESET_VALUE = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_en_i,
   input  logic [6:0]                   wr_id_i,
   input  logic [REG_BITS-1:0]          wr_data_i,
   input  logic [6:0]                   rd_id_i,
   output logic [REG_BITS-1:0]          rd_data_o,
   input  logic [NUM_REGS*REG_BITS-1:0] status_i,
   output logic [NUM_REGS*REG_BITS-1:0] regs_o,
   output logic [NUM_REGS-1:0]          strobe_o
);

   logic [REG_BITS-1:0] regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] strobe_q;

   // Register file update and strobe generation
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the storage is reset element by element so the full RESET_VALUE image is restored and no half-written register survives; this rules out mapping it onto a RAM macro.
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RESET_VALUE[i*REG_BITS +: REG_BITS];
         end
         strobe_q <= '0;
      end else begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
         strobe_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en_i && (wr_id_i == 7'(i)) && !RO_MASK[i]) begin
               regs_q[i]   <= wr_data_i;
               strobe_q[i] <= 1'b1;
            end
         end
      end
   end

   // Read mux: read-only registers return the live status input
   always_comb begin
      // NOTE: a default before the loop keeps this purely combinational; without it an unmatched id would infer a latch.
      rd_data_o = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_id_i == 7'(i)) begin
            rd_data_o = RO_MASK[i] ? status_i[i*REG_BITS +: REG_BITS] : regs_q[i];
         end
      end
   end

   // Flatten the storage onto the output bus
   always_comb begin
      regs_o = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_o[i*REG_BITS +: REG_BITS] = regs_q[i];
      end
   end

   assign strobe_o = strobe_q;

endmodule

// File: rtl/uart_reg_bank_ctrl.sv
// UART command decoder: parses {rw,id},len,data byte streams, writes or reads
// the register bank and answers with ACK/NAK plus read data.
module uart_reg_bank_ctrl
   import uart_monitor_pkg::*;
#(
   parameter int                           NUM_REGS       = 8,
   parameter int                           REG_BITS       = 32,
   parameter logic [NUM_REGS-1:0]          RO_MASK        = '0,
   parameter logic [NUM_REGS*REG_BITS-1:0] RESET_VALUE    = '0,
   parameter int                           TIMEOUT_CYCLES = 100000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         rx_valid,
   input  logic [7:0]                   rx_data,
   input  logic                         rx_error,
   input  logic                         rts_n,
   output logic                         cts_n,
   output logic [7:0]                   tx_data,
   output logic                         tx_valid,
   input  logic                         tx_ready,
   input  logic [NUM_REGS*REG_BITS-1:0] status_in,
   output logic [NUM_REGS*REG_BITS-1:0] regs_out,
   output logic [NUM_REGS-1:0]          reg_wr_strobe,
   output logic                         busy,
   output logic                         err_pulse,
   output logic [1:0]                   err_code
);

   localparam int REG_BYTES = reg_bytes(REG_BITS);
   localparam int SH_W      = REG_BYTES * 8;
   localparam int IDX_W     = $clog2(REG_BYTES + 1);
   localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);

   state_e             state_q, state_d;
   logic [7:0]         cmd_q, cmd_d;
   logic [7:0]         len_q, len_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [SH_W-1:0]    shadow_q, shadow_d;
   logic [SH_W-1:0]    snap_q, snap_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               bad_q, bad_d;
   logic               wr_q, wr_d;
   logic               err_pulse_q, err_pulse_d;
   err_e               err_code_q, err_code_d;

   logic               rcv;
   logic               ro_hit;
   logic               cmd_ok;
   logic [REG_BITS-1:0] rd_data;

   assign rcv = (state_q == CMD) || (state_q == LEN) || (state_q == WDATA) || (state_q == DRAIN);

   reg_bank #(
      .NUM_REGS    (NUM_REGS),
      .REG_BITS    (REG_BITS),
      .RO_MASK     (RO_MASK),
      .RESET_VALUE (RESET_VALUE)
   ) u_reg_bank (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (wr_q),
      .wr_id_i   (cmd_q[6:0]),
      .wr_data_i (shadow_q[REG_BITS-1:0]),
      .rd_id_i   (cmd_q[6:0]),
      .rd_data_o (rd_data),
      .status_i  (status_in),
      .regs_o    (regs_out),
      .strobe_o  (reg_wr_strobe)
   );

   // Command validity: id in range, 1..REG_BYTES bytes, no write to a read-only register
   always_comb begin
      ro_hit = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (cmd_q[6:0] == 7'(i)) ro_hit = RO_MASK[i];
      end
      cmd_ok = (32'(cmd_q[6:0]) < NUM_REGS) && (rx_data != 8'd0) &&
               (32'(rx_data) <= REG_BYTES) && !(cmd_q[7] && ro_hit);
   end

   // Next-state logic for the FSM, shadow/snapshot buffers and timeout counter
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      len_d       = len_q;
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      snap_d      = snap_q;
      tx_data_d   = tx_data_q;
      bad_d       = bad_q;
      wr_d        = 1'b0;
      err_pulse_d = 1'b0;
      err_code_d  = err_code_q;
      tmo_d       = (rx_valid || !rcv) ? '0 : tmo_q + TMO_W'(1);

      case (state_q)
         IDLE: begin
            if (!rts_n) state_d = CMD;
         end
         CMD: begin
            if (rx_valid) begin
               cmd_d   = rx_data;
               state_d = LEN;
            end
         end
         LEN: begin
            if (rx_valid) begin
               len_d = rx_data;
               bad_d = !cmd_ok;
               idx_d = '0;
               if (cmd_q[7]) begin
                  shadow_d = '0;
                  state_d  = cmd_ok ? WDATA : DRAIN;
               end else begin
                  snap_d    = SH_W'(rd_data);
                  tx_data_d = cmd_ok ? ACK_BYTE : NAK_BYTE;
                  state_d   = RESP;
               end
            end
         end
         WDATA: begin
            if (rx_valid) begin
               for (int b = 0; b < REG_BYTES; b++) begin
                  if (idx_q == IDX_W'(b)) shadow_d[b*8 +: 8] = rx_data;
               end
               idx_d = idx_q + IDX_W'(1);
               if (8'(idx_q) + 8'd1 == len_q) begin
                  wr_d      = 1'b1;
                  tx_data_d = ACK_BYTE;
                  state_d   = RESP;
               end
            end
         end
         DRAIN: begin
            if (len_q == 8'd0) begin
               tx_data_d = NAK_BYTE;
               state_d   = RESP;
            end else if (rx_valid) begin
               len_d = len_q - 8'd1;
            end
         end
         RESP: begin
            if (tx_ready) begin
               if (!bad_q && !cmd_q[7]) begin
                  tx_data_d = snap_q[7:0];
                  snap_d    = snap_q >> 8;
                  idx_d     = '0;
                  state_d   = RDATA;
               end else begin
                  state_d = IDLE;
                  if (bad_q) begin
                     err_pulse_d = 1'b1;
                     err_code_d  = ERR_BAD;
                  end
               end
            end
         end
         RDATA: begin
            if (tx_ready) begin
               if (8'(idx_q) + 8'd1 == len_q) begin
                  state_d = IDLE;
               end else begin
                  idx_d     = idx_q + IDX_W'(1);
                  tx_data_d = snap_q[7:0];
                  snap_d    = snap_q >> 8;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Aborts while receiving: a line error beats the byte, a byte beats the timeout
      if (rcv) begin
         if (rx_error) begin
            state_d     = IDLE;
            wr_d        = 1'b0;
            err_pulse_d = 1'b1;
            err_code_d  = ERR_RX;
         end else if (!rx_valid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1))) begin
            state_d     = IDLE;
            wr_d        = 1'b0;
            err_pulse_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
         end
      end
   end

   // State register; synchronous reset discards any command in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cmd_q       <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         shadow_q    <= '0;
         snap_q      <= '0;
         tmo_q       <= '0;
         tx_data_q   <= '0;
         bad_q       <= 1'b0;
         wr_q        <= 1'b0;
         err_pulse_q <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
         snap_q      <= snap_d;
         tmo_q       <= tmo_d;
         tx_data_q   <= tx_data_d;
         bad_q       <= bad_d;
         wr_q        <= wr_d;
         err_pulse_q <= err_pulse_d;
         err_code_q  <= err_code_d;
      end
   end

   assign cts_n     = !rcv;
   assign tx_valid  = (state_q == RESP) || (state_q == RDATA);
   assign tx_data   = tx_data_q;
   assign busy      = (state_q != IDLE);
   assign err_pulse = err_pulse_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_reg_bank_ctrl.sv
// Directed bench for uart_reg_bank_ctrl: writes, reads, invalid commands,
// read-only registers, timeout, rx_error abort and mid-command reset.
module tb_uart_reg_bank_ctrl;

   localparam int NR  = 8;
   localparam int RB  = 32;
   localparam int TMO = 50;
   localparam logic [NR-1:0]    ROM  = 8'h01;
   localparam logic [NR*RB-1:0] RSTV = {32'h107, 32'h106, 32'h105, 32'h104,
                                        32'h103, 32'h102, 32'h101, 32'h100};

   logic             clk = 1'b0;
   logic             reset;
   logic             rx_valid;
   logic [7:0]       rx_data;
   logic             rx_error;
   logic             rts_n;
   logic             cts_n;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [NR*RB-1:0] status_in;
   logic [NR*RB-1:0] regs_out;
   logic [NR-1:0]    reg_wr_strobe;
   logic             busy;
   logic             err_pulse;
   logic [1:0]       err_code;

   uart_reg_bank_ctrl #(
      .NUM_REGS       (NR),
      .REG_BITS       (RB),
      .RO_MASK        (ROM),
      .RESET_VALUE    (RSTV),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .rx_error      (rx_error),
      .rts_n         (rts_n),
      .cts_n         (cts_n),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .status_in     (status_in),
      .regs_out      (regs_out),
      .reg_wr_strobe (reg_wr_strobe),
      .busy          (busy),
      .err_pulse     (err_pulse),
      .err_code      (err_code)
   );

   always #5 clk = ~clk;

   int         total = 0;
   int         bad   = 0;

   // Monitor state, only ever advanced by the monitor
   logic [7:0] txq[$];
   int         strobe_cnt  = 0;
   logic [7:0] strobe_last = '0;
   int         err_cnt     = 0;

   // Baselines captured by the stimulus before each command
   int         base_tx, base_strobe, base_err;

   always @(negedge clk) begin
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (reg_wr_strobe != '0) begin
         strobe_cnt  = strobe_cnt + 1;
         strobe_last = reg_wr_strobe;
      end
      if (err_pulse) err_cnt = err_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] reg_of(input int i);
      return regs_out[i*RB +: RB];
   endfunction

   task automatic mark;
      base_tx     = txq.size();
      base_strobe = strobe_cnt;
      base_err    = err_cnt;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic err);
      @(posedge clk); #2;
      rx_valid = 1'b1;
      rx_data  = b;
      rx_error = err;
      @(posedge clk); #2;
      rx_valid = 1'b0;
      rx_error = 1'b0;
   endtask

   task automatic open_cmd(input string tag);
      int n = 0;
      rts_n = 1'b0;
      do begin
         @(negedge clk);
         n++;
      end while (cts_n && n < 20);
      check({tag, "_cts"}, 64'(cts_n), 64'd0);
   endtask

   // Bytes are packed LSB-first: byte k is bytes[8k +: 8]
   task automatic send_cmd(input string tag, input int n, input logic [63:0] bytes);
      open_cmd(tag);
      for (int k = 0; k < n; k++) send_byte(bytes[8*k +: 8], 1'b0);
      rts_n = 1'b1;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      @(negedge clk);
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle"}, 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_tx(input string tag, input int n, input logic [63:0] exp);
      int got;
      got = txq.size() - base_tx;
      check({tag, "_txcnt"}, 64'(got), 64'(n));
      for (int k = 0; k < n; k++) begin
         check($sformatf("%s_tx%0d", tag, k),
               (k < got) ? 64'(txq[base_tx + k]) : 64'hFFFF, 64'(exp[8*k +: 8]));
      end
   endtask

   task automatic check_strobe(input string tag, input int n, input logic [7:0] last);
      check({tag, "_stbcnt"}, 64'(strobe_cnt - base_strobe), 64'(n));
      if (n > 0) check({tag, "_stb"}, 64'(strobe_last), 64'(last));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      rts_n     = 1'b1;
      rx_valid  = 1'b0;
      rx_data   = '0;
      rx_error  = 1'b0;
      tx_ready  = 1'b1;
      status_in = '0;
      status_in[31:0]  = 32'hDEADBEEF;
      status_in[63:32] = 32'h11111111;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);

      // Reset state
      for (int i = 0; i < NR; i++) check($sformatf("rst_reg%0d", i), 64'(reg_of(i)), 64'(32'h100 + i));
      check("rst_cts_n",  64'(cts_n),         64'd1);
      check("rst_txv",    64'(tx_valid),      64'd0);
      check("rst_txd",    64'(tx_data),       64'd0);
      check("rst_stb",    64'(reg_wr_strobe), 64'd0);
      check("rst_busy",   64'(busy),          64'd0);
      check("rst_errp",   64'(err_pulse),     64'd0);
      check("rst_errc",   64'(err_code),      64'd0);

      // Full write to reg3
      mark();
      send_cmd("w3", 6, 64'h44_33_22_11_04_83);
      wait_idle("w3", 20);
      check("w3_reg", 64'(reg_of(3)), 64'h44332211);
      check_strobe("w3", 1, 8'h08);
      check_tx("w3", 1, 64'hA5);
      check("w3_err", 64'(err_cnt - base_err), 64'd0);

      // Partial write to reg1, then full-length read back
      mark();
      send_cmd("w1", 4, 64'hBB_AA_02_81);
      wait_idle("w1", 20);
      check("w1_reg", 64'(reg_of(1)), 64'h0000BBAA);
      check_strobe("w1", 1, 8'h02);
      check_tx("w1", 1, 64'hA5);
      mark();
      send_cmd("r1", 2, 64'h04_01);
      wait_idle("r1", 40);
      check_tx("r1", 5, 64'h00_00_BB_AA_A5);
      check_strobe("r1", 0, 8'h00);

      // Write to out-of-range id: one byte drained, NAK, error 1
      mark();
      send_cmd("bid", 3, 64'h00_01_89);
      wait_idle("bid", 20);
      check_tx("bid", 1, 64'h5A);
      check("bid_errc", 64'(err_code), 64'd1);
      check("bid_errn", 64'(err_cnt - base_err), 64'd1);
      check_strobe("bid", 0, 8'h00);

      // Read with len > REG_BYTES: NAK alone
      mark();
      send_cmd("blen", 2, 64'h05_02);
      wait_idle("blen", 20);
      check_tx("blen", 1, 64'h5A);
      check("blen_errn", 64'(err_cnt - base_err), 64'd1);

      // Read-only reg0 with a stalled transmitter; status changes after the snapshot
      mark();
      tx_ready = 1'b0;
      send_cmd("ro", 2, 64'h04_00);
      repeat (3) @(negedge clk);
      check("ro_hold_v", 64'(tx_valid), 64'd1);
      check("ro_hold_d", 64'(tx_data),  64'hA5);
      check("ro_cts_n",  64'(cts_n),    64'd1);
      status_in[31:0] = 32'h12345678;
      @(posedge clk); #2 tx_ready = 1'b1;
      wait_idle("ro", 40);
      check_tx("ro", 5, 64'hDE_AD_BE_EF_A5);
      status_in[31:0] = 32'hDEADBEEF;

      // Write to read-only reg0 is drained and refused
      mark();
      send_cmd("row", 6, 64'h04_03_02_01_04_80);
      wait_idle("row", 20);
      check_tx("row", 1, 64'h5A);
      check("row_reg", 64'(reg_of(0)), 64'h100);
      check_strobe("row", 0, 8'h00);
      check("row_errn", 64'(err_cnt - base_err), 64'd1);

      // Inter-byte timeout mid-write
      mark();
      send_cmd("tmo", 3, 64'h01_04_82);
      repeat (40) @(negedge clk);
      check("tmo_early_busy", 64'(busy),  64'd1);
      check("tmo_early_cts",  64'(cts_n), 64'd0);
      wait_idle("tmo", 40);
      check("tmo_errc", 64'(err_code), 64'd2);
      check("tmo_errn", 64'(err_cnt - base_err), 64'd1);
      check("tmo_cts",  64'(cts_n), 64'd1);
      check("tmo_reg",  64'(reg_of(2)), 64'h102);
      check_tx("tmo", 0, 64'h0);
      check_strobe("tmo", 0, 8'h00);

      // Next command after the timeout succeeds
      mark();
      send_cmd("w2", 3, 64'h5C_01_82);
      wait_idle("w2", 20);
      check("w2_reg", 64'(reg_of(2)), 64'h5C);
      check_strobe("w2", 1, 8'h04);
      check_tx("w2", 1, 64'hA5);

      // rx_error on a data byte aborts with no write and no response
      mark();
      open_cmd("rxe");
      send_byte(8'h83, 1'b0);
      send_byte(8'h04, 1'b0);
      send_byte(8'h77, 1'b1);
      rts_n = 1'b1;
      wait_idle("rxe", 20);
      check("rxe_errc", 64'(err_code), 64'd3);
      check("rxe_errn", 64'(err_cnt - base_err), 64'd1);
      check("rxe_reg",  64'(reg_of(3)), 64'h44332211);
      check_tx("rxe", 0, 64'h0);
      check_strobe("rxe", 0, 8'h00);

      // Reset during WDATA after 2 of 4 bytes
      mark();
      open_cmd("rst");
      send_byte(8'h85, 1'b0);
      send_byte(8'h04, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      rts_n = 1'b1;
      @(posedge clk); #2 reset = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NR; i++) check($sformatf("rst2_reg%0d", i), 64'(reg_of(i)), 64'(32'h100 + i));
      check("rst2_busy", 64'(busy),     64'd0);
      check("rst2_cts",  64'(cts_n),    64'd1);
      check("rst2_txv",  64'(tx_valid), 64'd0);
      check("rst2_errc", 64'(err_code), 64'd0);
      repeat (3) @(negedge clk);
      check_tx("rst2", 0, 64'h0);
      check_strobe("rst2", 0, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_reg_bank_ctrl.md
Name: uart_reg_bank_ctrl

Overview:
- Parametrised UART command/register-bank controller.
- Sits between byte-level uart_rx/uart_tx instances and a bank of NUM_REGS registers, each REG_BITS wide. Writable registers are control outputs; read-only registers mirror hardware status inputs.
- Over the single-generation monitor it adds: parametrised register count and width, length checking, ACK/NAK responses, an inter-byte timeout, rx-error abort, and per-register write strobes.

Parameters:
- NUM_REGS, 8, number of registers; 1..127.
- REG_BITS, 32, width of each register; 8..64. REG_BYTES = ceil(REG_BITS/8).
- RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes reg i read-only, with read data taken from status_in.
- RESET_VALUE, 0, NUM_REGS*REG_BITS flat reset image of all registers.
- TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between received bytes of one command.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- rx_valid  in  1  one-cycle pulse; rx_data holds a received byte
- rx_data  in  8  received byte
- rx_error  in  1  one-cycle pulse; parity or framing error on the current byte
- rts_n  in  1  host request-to-send, active-low
- cts_n  out  1  clear-to-send, active-low
- tx_data  out  8  byte to transmit
- tx_valid  out  1  transmit request
- tx_ready  in  1  transmitter accepts the byte when tx_valid&&tx_ready
- status_in  in  NUM_REGS*REG_BITS  hardware values returned for read-only registers
- regs_out  out  NUM_REGS*REG_BITS  current register contents
- reg_wr_strobe  out  NUM_REGS  one-hot, one-cycle pulse when a register is committed
- busy  out  1  high in any state other than IDLE
- err_pulse  out  1  one-cycle pulse when a command terminates with an error
- err_code  out  2  0 none, 1 bad id/len, 2 timeout, 3 rx_error; held until the next err_pulse

Behaviour:
- Reset values: regs_out=RESET_VALUE, cts_n=1, tx_valid=0, tx_data=0, strobes=0, err_pulse=0, err_code=0, state=IDLE.
- Reset wins over every other event, including mid-command; no partial register write survives.
- Protocol:
  - byte0 = {rw, id[6:0]}; rw=1 is write.
  - byte1 = len.
  - Write: len data bytes follow, LSB byte first; the block then sends ACK 0xA5 or NAK 0x5A.
  - Read: the block sends ACK followed by len bytes LSB-first, or NAK alone.
- Command is invalid (code 1) if id>=NUM_REGS, len==0, len>REG_BYTES, or rw=1 with RO_MASK[id]=1.
- States:
  - IDLE: cts_n=1. When rts_n=0, go to CMD; cts_n=0 from the next cycle.
  - CMD: on rx_valid, latch the command byte and go to LEN.
  - LEN: on rx_valid, latch len and check validity.
    - Valid write -> WDATA, with the shadow buffer cleared to 0.
    - Invalid write -> DRAIN.
    - Valid read -> snapshot the register (status_in for RO regs) and go to RESP(ACK).
    - Invalid read -> RESP(NAK).
  - WDATA: each rx_valid stores a byte at index idx and increments idx. After byte len-1 is accepted:
    - next cycle: the register is loaded with the shadow value; bytes above len are 0; bits above REG_BITS are dropped;
    - the matching reg_wr_strobe bit pulses that same cycle;
    - go to RESP(ACK).
  - DRAIN: discard len bytes, then go to RESP(NAK).
  - RESP: hold tx_valid and tx_data until the handshake completes.
    - After ACK on a read -> RDATA.
    - Otherwise -> IDLE; err_pulse fires at this transition if the command was invalid.
  - RDATA: send snapshot bytes 0..len-1, one per handshake, then go to IDLE.
- cts_n=0 only in CMD, LEN, WDATA and DRAIN; cts_n=1 in every other state.
- Timeout: a counter clears on every rx_valid and on entry to CMD. If it reaches TIMEOUT_CYCLES in CMD, LEN, WDATA or DRAIN:
  - abort to IDLE with no write and no response;
  - err_pulse fires with err_code=2.
- rx_error in a receiving state: abort to IDLE immediately, no response, err_code=3.
- rx_valid in IDLE, RESP or RDATA is ignored.
- rx_valid and a timeout in the same cycle: the byte wins and the counter clears.
- The read snapshot is taken at the LEN cycle; later register or status changes do not affect the bytes sent.
- The byte index is $clog2(REG_BYTES+1) bits wide; len is compared at full 8 bits.

Decomposition:
- Package uart_monitor_pkg holds:
  - ACK/NAK byte constants;
  - state enum (IDLE, CMD, LEN, WDATA, DRAIN, RESP, RDATA);
  - err_code enum;
  - REG_BYTES helper function.
- Sub-module reg_bank: holds the storage, RESET_VALUE load, RO_MASK bypass to status_in, and the one-hot strobe generation. The FSM, shadow buffer and timeout counter stay in uart_reg_bank_ctrl.

Test Plan:
- Write, NUM_REGS=8, REG_BITS=32: bytes 0x83,0x04,0x11,0x22,0x33,0x44 -> regs_out[3]=0x44332211; reg_wr_strobe=0x08 for one cycle; tx byte 0xA5.
- Partial write: 0x81,0x02,0xAA,0xBB -> reg1=0x0000BBAA; ACK. Then read 0x01,0x04 -> tx A5,AA,BB,00,00.
- Invalid commands:
  - 0x89,0x01,0x00 (id 9) -> byte drained; tx 0x5A; err_code=1; no strobe.
  - Read 0x02,0x05 -> tx 0x5A only.
- Read-only register, RO_MASK=0x01, status_in[0]=0xDEADBEEF: read 0x00,0x04 -> A5,EF,BE,AD,DE. Write 0x80,... -> NAK; reg0 unchanged.
- Timeout, TIMEOUT_CYCLES=50: send 0x82,0x04,0x01, then idle 50 cycles -> err_code=2; no tx; cts_n=1; reg2 unchanged. The next command succeeds.
- Reset asserted during WDATA after 2 of 4 bytes -> regs_out=RESET_VALUE; state IDLE; no strobe and no tx.
